// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the instruction-fetch front end.
// Supports increment, jump, timed delay, call/return through a hardware
// return-address stack, and halt. It also has stall control and sticky
// overflow/underflow flags.
module pc_sequencer #(
    parameter int                ADDR_W      = 20,
    parameter int                DELAY_W     = 10,
    parameter int                STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    localparam int               SW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [2:0]         cmd,
    input  logic [ADDR_W-1:0]  new_address,
    input  logic [DELAY_W-1:0] delay_cycles,
    input  logic               stall,
    output logic [ADDR_W-1:0]  address,
    output logic               busy,
    output logic               halted,
    output logic [SW-1:0]      stack_count,
    output logic               overflow,
    output logic               underflow
);

    localparam int          IW         = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SW-1:0] FULL_COUNT = SW'(STACK_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CMD_HOLD  = 3'd0,
        CMD_INC   = 3'd1,
        CMD_JUMP  = 3'd2,
        CMD_DELAY = 3'd3,
        CMD_CALL  = 3'd4,
        CMD_RET   = 3'd5,
        CMD_HALT  = 3'd6,
        CMD_RSVD  = 3'd7
    } cmd_t;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [DELAY_W-1:0] delay_count, delay_count_n;
    logic [SW-1:0]      count_n;
    logic               overflow_n, underflow_n;
    logic               push;
    logic [ADDR_W-1:0]  addr_inc;
    logic [IW-1:0]      push_idx, pop_idx;
    logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];

    assign addr_inc = address + ADDR_W'(1);
    assign push_idx = IW'(stack_count);
    assign pop_idx  = IW'(stack_count - SW'(1));
    assign busy     = (state == ST_WAIT);
    assign halted   = (state == ST_HALT);

    // State register: reset beats stall, stall freezes everything.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before this edge.
        if (reset) begin
            state       <= ST_RUN;
            address     <= RESET_ADDR;
            delay_count <= '0;
            stack_count <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            state       <= state_n;
            address     <= addr_n;
            delay_count <= delay_count_n;
            stack_count <= count_n;
            overflow    <= overflow_n;
            underflow   <= underflow_n;
        end
    end

    // Return-address storage: written on an accepted CALL.
    always_ff @(posedge clock) begin
        // NOTE: the stack array has no reset. stack_count alone defines
        // which entries are valid, so the storage can map onto plain RAM.
        if (!reset && push) begin
            stack_mem[push_idx] <= addr_inc;
        end
    end

    // Next-state and command decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_n       = state;
        addr_n        = address;
        delay_count_n = delay_count;
        count_n       = stack_count;
        overflow_n    = overflow;
        underflow_n   = underflow;
        push          = 1'b0;

        if (!stall) begin
            case (state)
                ST_RUN: begin
                    case (cmd_t'(cmd))
                        CMD_INC:  addr_n = addr_inc;
                        CMD_JUMP: addr_n = new_address;
                        CMD_DELAY: begin
                            if (delay_cycles == '0) begin
                                addr_n = addr_inc;
                            end else begin
                                delay_count_n = delay_cycles;
                                state_n       = ST_WAIT;
                            end
                        end
                        CMD_CALL: begin
                            if (stack_count == FULL_COUNT) begin
                                overflow_n = 1'b1;
                            end else begin
                                push    = 1'b1;
                                count_n = stack_count + SW'(1);
                                addr_n  = new_address;
                            end
                        end
                        CMD_RET: begin
                            if (stack_count == '0) begin
                                underflow_n = 1'b1;
                            end else begin
                                addr_n  = stack_mem[pop_idx];
                                count_n = stack_count - SW'(1);
                            end
                        end
                        CMD_HALT: state_n = ST_HALT;
                        default:  ;
                    endcase
                end
                ST_WAIT: begin
                    // cmd is ignored. The edge that sees the counter at 1
                    // finishes the delay and advances the PC.
                    delay_count_n = delay_count - DELAY_W'(1);
                    if (delay_count == DELAY_W'(1)) begin
                        addr_n  = addr_inc;
                        state_n = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. A queue-based behavioural model is
// compared against the DUT on every cycle. Directed sequences also carry
// literal expectations that pin the model.
module tb_pc_sequencer;

    localparam int ADDR_W      = 12;
    localparam int DELAY_W     = 10;
    localparam int STACK_DEPTH = 2;
    localparam int SW          = $clog2(STACK_DEPTH + 1);

    localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, JUMP = 3'd2, DELAY = 3'd3,
                           CALL = 3'd4, RET = 3'd5, HALT = 3'd6, RSVD = 3'd7;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [2:0]         cmd = '0;
    logic [ADDR_W-1:0]  new_address = '0;
    logic [DELAY_W-1:0] delay_cycles = '0;
    logic               stall = 1'b0;
    logic [ADDR_W-1:0]  address;
    logic               busy;
    logic               halted;
    logic [SW-1:0]      stack_count;
    logic               overflow;
    logic               underflow;

    pc_sequencer #(
        .ADDR_W      (ADDR_W),
        .DELAY_W     (DELAY_W),
        .STACK_DEPTH (STACK_DEPTH),
        .RESET_ADDR  ('0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd          (cmd),
        .new_address  (new_address),
        .delay_cycles (delay_cycles),
        .stall        (stall),
        .address      (address),
        .busy         (busy),
        .halted       (halted),
        .stack_count  (stack_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: PC value, remaining delay edges, queue as the stack.
    logic [ADDR_W-1:0] m_addr = '0;
    int                m_wait = 0;
    bit                m_halted = 0;
    bit                m_ovf = 0;
    bit                m_unf = 0;
    bit                model_valid = 0;
    logic [ADDR_W-1:0] m_stack [$];

    always @(posedge clock) begin
        if (reset) begin
            m_addr = '0;
            m_wait = 0;
            m_halted = 0;
            m_ovf = 0;
            m_unf = 0;
            m_stack.delete();
            model_valid = 1;
        end else if (model_valid && !stall && !m_halted) begin
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_addr++;
            end else begin
                case (cmd)
                    INC:   m_addr++;
                    JUMP:  m_addr = new_address;
                    DELAY: if (delay_cycles == 0) m_addr++; else m_wait = int'(delay_cycles);
                    CALL: begin
                        if (m_stack.size() == STACK_DEPTH) m_ovf = 1;
                        else begin
                            m_stack.push_back(m_addr + 12'd1);
                            m_addr = new_address;
                        end
                    end
                    RET: begin
                        if (m_stack.size() == 0) m_unf = 1;
                        else m_addr = m_stack.pop_back();
                    end
                    HALT:    m_halted = 1;
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (model_valid) begin
            check("address", 32'(address), 32'(m_addr));
            check("busy", 32'(busy), 32'(m_wait > 0));
            check("halted", 32'(halted), 32'(m_halted));
            check("stack_count", 32'(stack_count), 32'(m_stack.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("underflow", 32'(underflow), 32'(m_unf));
        end
    end

    task automatic step(input logic [2:0] c, input logic [ADDR_W-1:0] na,
                        input logic [DELAY_W-1:0] dl, input logic st, input logic rs);
        @(negedge clock);
        cmd = c;
        new_address = na;
        delay_cycles = dl;
        stall = st;
        reset = rs;
        @(posedge clock);
        #1;
    endtask

    initial begin
        step(HOLD, '0, '0, 0, 1);
        step(HOLD, '0, '0, 0, 1);
        check("rst_addr", 32'(address), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_count", 32'(stack_count), 32'h0);

        for (int i = 1; i <= 3; i++) begin
            step(INC, '0, '0, 0, 0);
            check("inc_addr", 32'(address), 32'(i));
        end
        step(INC, '0, '0, 1, 0);
        check("stall_inc", 32'(address), 32'h3);
        step(RSVD, '0, '0, 0, 0);
        check("rsvd_hold", 32'(address), 32'h3);
        step(DELAY, '0, '0, 0, 0);
        check("delay0_inc", 32'(address), 32'h4);
        check("delay0_busy", 32'(busy), 32'h0);

        step(JUMP, 12'hFFF, '0, 0, 0);
        check("jump_max", 32'(address), 32'hFFF);
        step(INC, '0, '0, 0, 0);
        check("wrap", 32'(address), 32'h0);

        // DELAY 150 at address 5, INC presented throughout.
        step(JUMP, 12'h005, '0, 0, 0);
        step(DELAY, '0, 10'd150, 0, 0);
        check("dly_accept_busy", 32'(busy), 32'h1);
        for (int i = 1; i <= 150; i++) begin
            step(INC, '0, '0, 0, 0);
            check("dly_busy", 32'(busy), 32'(i < 150));
            check("dly_addr", 32'(address), (i < 150) ? 32'h5 : 32'h6);
        end
        step(HOLD, '0, '0, 0, 0);
        check("dly_end_ignored", 32'(address), 32'h6);

        // Same delay with a 3-cycle stall mid-wait: finishes at edge 153.
        step(DELAY, '0, 10'd150, 0, 0);
        for (int i = 1; i <= 153; i++) begin
            step(INC, '0, '0, (i >= 50 && i <= 52), 0);
            check("stl_busy", 32'(busy), 32'(i < 153));
            check("stl_addr", 32'(address), (i < 153) ? 32'h6 : 32'h7);
        end

        // Call / return.
        step(JUMP, 12'h010, '0, 0, 0);
        step(CALL, 12'h100, '0, 0, 0);
        check("call_addr", 32'(address), 32'h100);
        check("call_count", 32'(stack_count), 32'h1);
        step(RET, '0, '0, 0, 0);
        check("ret_addr", 32'(address), 32'h11);
        check("ret_count", 32'(stack_count), 32'h0);

        // Overflow then underflow with a 2-deep stack.
        step(JUMP, 12'h020, '0, 0, 0);
        step(CALL, 12'h200, '0, 0, 0);
        step(CALL, 12'h300, '0, 0, 0);
        step(CALL, 12'h400, '0, 0, 0);
        check("ovf_flag", 32'(overflow), 32'h1);
        check("ovf_addr", 32'(address), 32'h300);
        check("ovf_count", 32'(stack_count), 32'h2);
        step(RET, '0, '0, 0, 0);
        check("ret1_addr", 32'(address), 32'h201);
        step(RET, '0, '0, 0, 0);
        check("ret2_addr", 32'(address), 32'h21);
        step(RET, '0, '0, 0, 0);
        check("unf_flag", 32'(underflow), 32'h1);
        check("unf_addr", 32'(address), 32'h21);
        check("ovf_sticky", 32'(overflow), 32'h1);

        // Reset mid-delay (counter at 40), with stall held high as well.
        step(DELAY, '0, 10'd100, 0, 0);
        for (int i = 0; i < 60; i++) step(HOLD, '0, '0, 0, 0);
        check("mid_busy", 32'(busy), 32'h1);
        step(INC, '0, '0, 1, 1);
        check("rstmid_addr", 32'(address), 32'h0);
        check("rstmid_busy", 32'(busy), 32'h0);
        check("rstmid_ovf", 32'(overflow), 32'h0);
        check("rstmid_unf", 32'(underflow), 32'h0);
        step(HOLD, '0, '0, 0, 0);
        check("post_rst_idle", 32'(busy), 32'h0);

        // Halt ignores commands until reset.
        step(INC, '0, '0, 0, 0);
        step(HALT, '0, '0, 0, 0);
        check("halt_flag", 32'(halted), 32'h1);
        step(JUMP, 12'h055, '0, 0, 0);
        step(JUMP, 12'h055, '0, 0, 0);
        check("halt_addr", 32'(address), 32'h1);
        check("halt_hold", 32'(halted), 32'h1);
        step(HOLD, '0, '0, 0, 1);
        check("halt_rst_addr", 32'(address), 32'h0);
        check("halt_rst_flag", 32'(halted), 32'h0);

        step(HOLD, '0, '0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the instruction-fetch front end. It generalises the fixed 20-bit, 150-cycle-delay counter with configurable address width, a run-time delay length and a hardware return-address stack for call/return. It also adds stall, halt and sticky error flags. It sits between the control unit, which issues `cmd`, and instruction memory, which is indexed by `address`.

## Interface
Parameters:
- `ADDR_W`, default 20: address width; all address arithmetic is modulo 2^ADDR_W.
- `DELAY_W`, default 10: width of `delay_cycles` and of the internal delay counter.
- `STACK_DEPTH`, default 8: return-stack entries; must be ≥ 1.
- `RESET_ADDR`, default 0: value loaded into `address` on reset.

Ports (SW = clog2(STACK_DEPTH+1)):
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; overrides every other input.
- `cmd`  in  3  command: 0 HOLD, 1 INC, 2 JUMP, 3 DELAY, 4 CALL, 5 RET, 6 HALT, 7 reserved (treated as HOLD).
- `new_address`  in  ADDR_W  target address for JUMP/CALL.
- `delay_cycles`  in  DELAY_W  delay length N, sampled when DELAY is accepted.
- `stall`  in  1  freezes all state while high.
- `address`  out  ADDR_W  current PC, registered.
- `busy`  out  1  delay in progress; `cmd` is ignored while high.
- `halted`  out  1  HALT accepted; `cmd` is ignored until reset.
- `stack_count`  out  SW  number of valid stack entries.
- `overflow`  out  1  sticky: CALL attempted with the stack full.
- `underflow`  out  1  sticky: RET attempted with the stack empty.

## Operation
- States: RUN (busy=0, halted=0), WAIT (busy=1), HALT (halted=1).
- Reset, checked at every edge regardless of `stall` or state: address=RESET_ADDR, delay counter=0, busy=0, halted=0, stack_count=0, overflow=0, underflow=0. Stack contents are don't-care. Reset during WAIT aborts the delay.
- Priority at each edge: reset > stall > state behaviour. When `stall`=1 (and reset=0) nothing changes, including the delay counter.
- In RUN, `cmd` is accepted at each edge:
  - HOLD: no change.
  - INC: address+1; 2^ADDR_W−1 wraps to 0.
  - JUMP: address=new_address.
  - DELAY with N=0: acts as INC.
  - DELAY with N>0: counter=N, go to WAIT, address unchanged.
  - CALL, stack not full: push address+1 (wrapped), stack_count+1, address=new_address.
  - CALL, stack full: overflow=1; address and stack unchanged.
  - RET, stack not empty: address=top entry, pop, stack_count−1.
  - RET, stack empty: underflow=1; address unchanged.
  - HALT: go to HALT, address unchanged.
- In WAIT, `cmd` is ignored and the counter decrements each edge. At the edge where the counter is 1: counter becomes 0, address+1 (wrapped), return to RUN.
- In HALT, all outputs are held; only reset leaves this state.
- The stack is LIFO. Entries are ADDR_W wide and indexed by stack_count−1.

## Timing
- All outputs are registered and change only on rising edges; there are no combinational paths from input to output.
- INC, JUMP, CALL and RET take effect 1 edge after acceptance.
- DELAY with N>0 accepted at edge k: busy=1 after edge k; address advances and busy drops at edge k+N, provided `stall` stays low. Each stalled edge extends this by one edge.
- A command presented during the edge that ends WAIT is ignored. The first accepted command is at edge k+N+1.
- overflow and underflow assert 1 edge after the offending command and stay high until reset.

## Test plan
- Reset, then INC ×3: address goes 0→1→2→3. With ADDR_W=4, address=15 followed by INC gives 0.
- DELAY with N=150 at address 5: busy is high for 150 edges and address=6 at the 150th edge. Asserting INC during the wait has no effect. Repeat with stall pulsed for 3 cycles mid-wait: completion moves to edge 153.
- CALL with new_address=0x100 from address 0x10: address=0x100, stack_count=1. RET: address=0x11, stack_count=0.
- With STACK_DEPTH=2: CALL ×3: the third CALL sets overflow=1 and address stays at the second target. RET ×3: the third RET sets underflow=1 and address is unchanged.
- Reset asserted mid-delay (counter=40): next edge gives address=RESET_ADDR, busy=0, flags cleared. Stall held high together with reset: reset still wins.
- HALT: a following JUMP with new_address=0x55 is ignored and halted=1 holds; reset returns to address=0, halted=0.
